round_judge: RTL

Game-round controller for the not-not reaction game; it sits directly downstream of the colour-logic / not-not datapath. It paces rounds by pulsing the LFSR enable, then runs a per-round countdown. It captures the player's switch answer on a submit key press and compares it against the datapath's 4-bit expected answer. It keeps score and lives, and exposes countdown and status for the HEX/LEDR drivers.

---
 rtl/round_judge.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/round_judge.sv
// Round controller for the not-not reaction game: paces rounds, runs the countdown,
// judges the player's answer against the datapath and tracks score and lives.
module round_judge #(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int ROUND_SECS    = 5,
    parameter int LIVES         = 3
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start_n,
    input  logic       submit_n,
    input  logic [3:0] answer,
    input  logic [3:0] expected,
    output logic       new_round,
    output logic       playing,
    output logic       game_over,
    output logic       last_correct,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic [3:0] secs_left
);

    localparam int             TW         = $clog2(TICKS_PER_SEC);
    localparam logic [TW-1:0]  TICK_MAX   = TW'(TICKS_PER_SEC - 1);
    localparam logic [3:0]     SECS_INIT  = 4'(ROUND_SECS);
    localparam logic [1:0]     LIVES_INIT = 2'(LIVES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PLAY,
        S_JUDGE,
        S_OVER
    } state_t;

    state_t        r_state;
    logic          r_start_s1, r_start_s2, r_start_s3;
    logic          r_submit_s1, r_submit_s2, r_submit_s3;
    logic [3:0]    r_ans_s1, r_ans_s2;
    logic [3:0]    r_captured;
    logic          r_miss;
    logic [TW-1:0] r_tick;
    logic [3:0]    r_secs;
    logic [7:0]    r_score;
    logic [1:0]    r_lives;
    logic          r_new_round;
    logic          r_playing;
    logic          r_game_over;
    logic          r_last_correct;

    logic          w_start_press;
    logic          w_submit_press;

    // Keys idle high, so their synchronisers reset to 1 to avoid a false press on release.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            {r_start_s3, r_start_s2, r_start_s1}    <= 3'b111;
            {r_submit_s3, r_submit_s2, r_submit_s1} <= 3'b111;
            r_ans_s1 <= 4'd0;
            r_ans_s2 <= 4'd0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the pre-edge value,
            // which is what turns this chain into a shift register rather than a wire.
            {r_start_s3, r_start_s2, r_start_s1}    <= {r_start_s2, r_start_s1, start_n};
            {r_submit_s3, r_submit_s2, r_submit_s1} <= {r_submit_s2, r_submit_s1, submit_n};
            r_ans_s1 <= answer;
            r_ans_s2 <= r_ans_s1;
        end
    end

    assign w_start_press  = r_start_s3 & ~r_start_s2;
    assign w_submit_press = r_submit_s3 & ~r_submit_s2;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state        <= S_IDLE;
            r_captured     <= 4'd0;
            r_miss         <= 1'b0;
            r_tick         <= '0;
            r_secs         <= 4'd0;
            r_score        <= 8'd0;
            r_lives        <= 2'd0;
            r_new_round    <= 1'b0;
            r_playing      <= 1'b0;
            r_game_over    <= 1'b0;
            r_last_correct <= 1'b0;
        end else begin
            r_new_round <= 1'b0;
            case (r_state)
                S_IDLE, S_OVER: begin
                    if (w_start_press) begin
                        r_score        <= 8'd0;
                        r_lives        <= LIVES_INIT;
                        r_last_correct <= 1'b0;
                        r_game_over    <= 1'b0;
                        r_new_round    <= 1'b1;
                        r_state        <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_secs    <= SECS_INIT;
                    r_tick    <= TICK_MAX;
                    r_playing <= 1'b1;
                    r_state   <= S_PLAY;
                end
                S_PLAY: begin
                    // A submit in the final tick takes priority over the timeout.
                    if (w_submit_press) begin
                        r_captured <= r_ans_s2;
                        r_miss     <= 1'b0;
                        r_playing  <= 1'b0;
                        r_state    <= S_JUDGE;
                    end else if (r_tick != '0) begin
                        r_tick <= r_tick - 1'b1;
                    end else begin
                        r_tick <= TICK_MAX;
                        r_secs <= r_secs - 1'b1;
                        if (r_secs == 4'd1) begin
                            r_miss    <= 1'b1;
                            r_playing <= 1'b0;
                            r_state   <= S_JUDGE;
                        end
                    end
                end
                S_JUDGE: begin
                    if (!r_miss && (r_captured == expected)) begin
                        if (r_score != 8'hFF) begin
                            r_score <= r_score + 1'b1;
                        end
                        r_last_correct <= 1'b1;
                        r_new_round    <= 1'b1;
                        r_state        <= S_LOAD;
                    end else begin
                        r_last_correct <= 1'b0;
                        r_lives        <= r_lives - 1'b1;
                        if (r_lives == 2'd1) begin
                            r_game_over <= 1'b1;
                            r_state     <= S_OVER;
                        end else begin
                            r_new_round <= 1'b1;
                            r_state     <= S_LOAD;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign new_round    = r_new_round;
    assign playing      = r_playing;
    assign game_over    = r_game_over;
    assign last_correct = r_last_correct;
    assign score        = r_score;
    assign lives        = r_lives;
    assign secs_left    = r_secs;

endmodule
